// File: rtl/tile_controller_pkg.sv
// -----------------------------------------------------------------------------
// tile_controller_pkg
// Shared definitions for the systolic-array tile sequencer:
//   - default ADDR_WIDTH / ARRAY_DIM used by tile_controller
//   - controller state encoding (IDLE, STREAM, DRAIN, DONE)
// -----------------------------------------------------------------------------
package tile_controller_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_ARRAY_DIM  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tile_controller_counter.sv
// -----------------------------------------------------------------------------
// tile_counter
// Wrapping up-counter used for the cycle, drain, column and row counters.
// Counts 0..last_i while en_i is high, then wraps to 0.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (count -> 0)
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : advance the count this cycle
//   last_i  : terminal count value (limit - 1)
//   count_o : current count
//   wrap_o  : high in the enabled cycle where the count sits at last_i,
//             i.e. the cycle after which it returns to 0
// -----------------------------------------------------------------------------
module tile_counter
  import tile_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] last_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == last_i);
  assign wrap_o  = en_i && at_last;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = at_last ? '0 : count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tile_controller.sv
// -----------------------------------------------------------------------------
// tile_controller
// Sequences a tiled matrix multiply P = A x B on an ARRAY_DIM x ARRAY_DIM
// systolic array. Tiles are visited column-fastest; each tile streams
// max(k, ARRAY_DIM) cycles of A/B reads (zero-feed bubbles past k), then
// optionally drains ARRAY_DIM result rows into the P buffer.
//
// Build option: define TILE_WRITEBACK_EN to include the DRAIN phase that
// writes P. Without it DRAIN never occurs, tiles advance directly at the end
// of STREAM and the P port (enp_o/wep_o/addrp_o) is held at 0.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   start_i                        level start request (sampled in IDLE)
//   busy_o                         high in STREAM and DRAIN
//   valid_o                        high in DONE
//   m_i, k_i, n_i                  matrix dimensions (captured at start)
//   base_addra_i/b/p               buffer base addresses (captured at start)
//   tile_begin_o, tile_end_o       first / last stream cycle of a tile
//   ensys_o, bubble_o              array enable, zero-feed cycle
//   ena_o/enb_o/enp_o              buffer enables
//   wea_o/web_o/wep_o              buffer write enables
//   addra_o/addrb_o/addrp_o        buffer addresses (modulo 2^ADDR_WIDTH)
// -----------------------------------------------------------------------------
module tile_controller
  import tile_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int ARRAY_DIM  = DEFAULT_ARRAY_DIM
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] m_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0] n_i,
  input  logic [ADDR_WIDTH-1:0] base_addra_i,
  input  logic [ADDR_WIDTH-1:0] base_addrb_i,
  input  logic [ADDR_WIDTH-1:0] base_addrp_i,
  output logic                  tile_begin_o,
  output logic                  tile_end_o,
  output logic                  ensys_o,
  output logic                  bubble_o,
  output logic                  ena_o,
  output logic                  enb_o,
  output logic                  enp_o,
  output logic                  wea_o,
  output logic                  web_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic [ADDR_WIDTH-1:0] addrb_o,
  output logic [ADDR_WIDTH-1:0] addrp_o
);

  localparam int                    DIM_LOG2 = $clog2(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0] DIM_W    = ADDR_WIDTH'(ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] m_q, m_d, k_q, k_d, n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d;

  logic                  dims_nz, capture, cnt_clr;
  logic [ADDR_WIDTH-1:0] row_tiles, col_tiles, row_last, col_last, len_last;
  logic [ADDR_WIDTH-1:0] cyc_q, col_q, row_q;
  logic                  cyc_en, cyc_wrap, tile_adv, col_wrap, row_wrap;

  assign dims_nz = (m_i != '0) && (k_i != '0) && (n_i != '0);
  assign capture = (state_q == IDLE) && start_i && dims_nz;
  assign cnt_clr = (state_q == IDLE);

  // Captured operation parameters
  always_comb begin
    m_d      = m_q;
    k_d      = k_q;
    n_d      = n_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    if (capture) begin
      m_d      = m_i;
      k_d      = k_i;
      n_d      = n_i;
      base_a_d = base_addra_i;
      base_b_d = base_addrb_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
    end else begin
      m_q      <= m_d;
      k_q      <= k_d;
      n_q      <= n_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
    end
  end

  // ceil(x / ARRAY_DIM) as shift plus a remainder bit, so a dimension near
  // 2^ADDR_WIDTH cannot overflow the way (x + ARRAY_DIM - 1) >> log2 would.
  assign row_tiles = (m_q >> DIM_LOG2) + ADDR_WIDTH'(|m_q[DIM_LOG2-1:0]);
  assign col_tiles = (n_q >> DIM_LOG2) + ADDR_WIDTH'(|n_q[DIM_LOG2-1:0]);
  assign row_last  = row_tiles - ONE;
  assign col_last  = col_tiles - ONE;
  assign len_last  = (k_q > DIM_W) ? (k_q - ONE) : (DIM_W - ONE);

  assign cyc_en = (state_q == STREAM);

  tile_counter #(.WIDTH(ADDR_WIDTH)) u_cyc_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (cyc_en),
    .last_i (len_last),
    .count_o(cyc_q),
    .wrap_o (cyc_wrap)
  );

`ifdef TILE_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] base_p_q, base_p_d;
  logic [ADDR_WIDTH-1:0] drn_q;
  logic                  drn_en, drn_wrap;

  assign base_p_d = capture ? base_addrp_i : base_p_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_p_q <= '0;
    end else begin
      base_p_q <= base_p_d;
    end
  end

  assign drn_en = (state_q == DRAIN);

  tile_counter #(.WIDTH(ADDR_WIDTH)) u_drn_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (drn_en),
    .last_i (DIM_W - ONE),
    .count_o(drn_q),
    .wrap_o (drn_wrap)
  );

  // A tile is finished once its results have been written back.
  assign tile_adv = drn_wrap;
`else
  // P is collected by an external capture block; its base is not needed here.
  logic unused_base_p;
  assign unused_base_p = ^base_addrp_i;

  assign tile_adv = cyc_wrap;
`endif

  tile_counter #(.WIDTH(ADDR_WIDTH)) u_col_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (tile_adv),
    .last_i (col_last),
    .count_o(col_q),
    .wrap_o (col_wrap)
  );

  // row_wrap doubles as "last tile finished" since it needs col_wrap too.
  tile_counter #(.WIDTH(ADDR_WIDTH)) u_row_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .en_i   (col_wrap),
    .last_i (row_last),
    .count_o(row_q),
    .wrap_o (row_wrap)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_i is only looked at in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = dims_nz ? STREAM : DONE;
        end
      end
      STREAM: begin
`ifdef TILE_WRITEBACK_EN
        if (cyc_wrap) begin
          state_d = DRAIN;
        end
`else
        if (row_wrap) begin
          state_d = DONE;
        end
`endif
      end
`ifdef TILE_WRITEBACK_EN
      DRAIN: begin
        if (row_wrap) begin
          state_d = DONE;
        end else if (drn_wrap) begin
          state_d = STREAM;
        end
      end
`endif
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state and counters.
  always_comb begin
    busy_o       = 1'b0;
    valid_o      = 1'b0;
    tile_begin_o = 1'b0;
    tile_end_o   = 1'b0;
    ensys_o      = 1'b0;
    bubble_o     = 1'b0;
    ena_o        = 1'b0;
    enb_o        = 1'b0;
    enp_o        = 1'b0;
    wep_o        = 1'b0;
    addra_o      = '0;
    addrb_o      = '0;
    addrp_o      = '0;
    case (state_q)
      STREAM: begin
        busy_o       = 1'b1;
        ensys_o      = 1'b1;
        tile_begin_o = (cyc_q == '0);
        tile_end_o   = (cyc_q == len_last);
        // Past k the array is fed zeros so short-k tiles still fill the array.
        bubble_o     = (cyc_q >= k_q);
        ena_o        = (cyc_q < k_q);
        enb_o        = (cyc_q < k_q);
        addra_o      = base_a_q + row_q * k_q + cyc_q;
        addrb_o      = base_b_q + col_q * k_q + cyc_q;
      end
`ifdef TILE_WRITEBACK_EN
      DRAIN: begin
        busy_o  = 1'b1;
        ensys_o = 1'b1;
        bubble_o = 1'b1;
        enp_o   = 1'b1;
        wep_o   = 1'b1;
        addrp_o = base_p_q + ((row_q * col_tiles + col_q) << DIM_LOG2) + drn_q;
      end
`endif
      DONE: begin
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  // A and B are read-only from this controller.
  assign wea_o = 1'b0;
  assign web_o = 1'b0;

endmodule

// File: doc/tile_controller.md
TILE_CONTROLLER -- requirements
Module: tile_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning the width of all dimension and address ports.
REQ-002 SHALL have parameter ARRAY_DIM, default 8, meaning the systolic array edge (power of two, 2..64).
REQ-003 SHALL have ports `clk_i  in  1  clock`; `rst_ni  in  1  asynchronous active-low reset`; one clock, all state on rising edge.
REQ-004 SHALL have ports `start_i  in  1  level start request`; `busy_o  out  1  operation in progress`; `valid_o  out  1  result complete`.
REQ-005 SHALL have ports `m_i, k_i, n_i  in  ADDR_WIDTH  matrix dimensions`; `base_addra_i, base_addrb_i, base_addrp_i  in  ADDR_WIDTH  buffer bases`.
REQ-006 SHALL have ports `tile_begin_o, tile_end_o  out  1  first/last stream cycle of a tile`; `ensys_o  out  1  array enable`; `bubble_o  out  1  zero-feed cycle`.
REQ-007 SHALL have ports `ena_o/enb_o/enp_o  out  1  buffer enables`; `wea_o/web_o/wep_o  out  1  write enables`; `addra_o/addrb_o/addrp_o  out  ADDR_WIDTH  addresses`.

Function
REQ-008 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-009 SHALL sample m_i/k_i/n_i/bases into registers on IDLE->STREAM; later input changes have no effect until next start.
REQ-010 SHALL compute row tiles R=ceil(m/ARRAY_DIM), col tiles C=ceil(n/ARRAY_DIM), stream length L=max(k, ARRAY_DIM), using shifts by log2(ARRAY_DIM).
REQ-011 IDLE: on start_i=1 with m,k,n all nonzero go to STREAM next cycle; any zero dimension goes directly to DONE.
REQ-012 STREAM: cycle counter 0..L-1 per tile; tile_begin_o=1 at count 0, tile_end_o=1 at count L-1; ensys_o=1; bubble_o=1 when count>=k.
REQ-013 STREAM: ena_o=enb_o=1 when count<k; addra_o=base_a+row_tile*k+count, addrb_o=base_b+col_tile*k+count, combinational from current counters (buffer read latency absorbed downstream); wea_o=web_o=0 always.
REQ-014 At tile_end_o go to DRAIN; DRAIN lasts ARRAY_DIM cycles with ensys_o=1, bubble_o=1.
REQ-015 DRAIN cycle d: enp_o=wep_o=1, addrp_o=base_p+((row_tile*C+col_tile)*ARRAY_DIM)+d.
REQ-016 Tile order column-fastest: col_tile increments after each DRAIN, wraps to 0 and increments row_tile; after last tile (R-1,C-1) DRAIN go to DONE.
REQ-017 DONE: valid_o=1, all enables 0; stay while start_i=1, go to IDLE when start_i=0.
REQ-018 start_i during STREAM/DRAIN SHALL be ignored.
REQ-019 busy_o=1 exactly in STREAM and DRAIN.
REQ-020 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; overflow wraps silently.

Reset
REQ-021 rst_ni low SHALL asynchronously force IDLE, clear all counters and captured registers, at any time including mid-tile.
REQ-022 Reset values: every output 0.
REQ-023 First start after deassertion SHALL behave as from power-up.

Configuration
REQ-024 Macro TILE_WRITEBACK_EN defined: DRAIN behaves per REQ-014/015.
REQ-025 TILE_WRITEBACK_EN undefined: DRAIN state absent; STREAM tile_end advances tile directly; enp_o, wep_o, addrp_o tied 0; a result-capture block outside handles P.

Structure
REQ-026 Shared package SHALL hold state encoding constants and the default ADDR_WIDTH/ARRAY_DIM.
REQ-027 Sub-module tile_counter (wrapping counter with limit input, enable, wrap flag) SHALL be instantiated for cycle, drain, col and row counters.

Verification (ARRAY_DIM=8, bases A=0x000, B=0x100, P=0x200)
REQ-028 m=k=n=8, start pulse-held -> one tile: addra 0..7, addrb 0x100..0x107, bubble_o never 1, addrp 0x200..0x207, valid_o 1 after 16 busy cycles.
REQ-029 m=16,k=4,n=8 -> 2 tiles; each STREAM 8 cycles, bubble_o=1 on counts 4..7; second tile addra 4..7, addrp 0x208..0x20F.
REQ-030 m=8,k=8,n=0 -> IDLE->DONE in one cycle, busy_o never 1, no enables asserted.
REQ-031 m=n=16,k=8, rst_ni low at 3rd tile STREAM count 5 -> all outputs 0 same cycle; restart completes 4 tiles normally.
REQ-032 Build without TILE_WRITEBACK_EN, m=n=16,k=8 -> 32 busy cycles, enp_o/wep_o never 1.
REQ-033 During STREAM, toggle start_i and change m_i -> no effect; DONE held until start_i=0.
